// File: rtl/eth_tx_pktbuf.sv
// eth_tx_pktbuf: store-and-forward AXI-Stream packet buffer feeding the 10G MAC TX port.
//
// Frames are written into a simple dual-port RAM and only become visible to the read side
// once their tlast beat has been committed. The MAC therefore sees gap-free tvalid within
// every frame and never sees a partial frame. Frames flagged bad (tuser on tlast) and frames
// that do not fit are rewound and dropped. The buffer never backpressures the encap side.
//
// Ports:
//   clk156, eth_rst          clock and asynchronous active-high reset
//   s_axis_*                 frame input from eth_encap (tready is 1 after reset release)
//   m_axis_*                 frame output to the MAC (tuser is always 0)
//   pkt_cnt, drop_cnt        forwarded / dropped frame counters
//
// Build option: define TX_PKTBUF_STATS_EN to build the live counters; otherwise pkt_cnt and
// drop_cnt are tied to zero and no counter registers exist.

module eth_tx_pktbuf #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk156,
  input  logic                  eth_rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [31:0]           pkt_cnt,
  output logic [31:0]           drop_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned EntW  = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MaxFree = ADDR_WIDTH'(Depth - 1);
  localparam logic [ADDR_WIDTH-1:0] PtrOne  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {WrIdle, WrFrame, WrDrop} wr_state_e;
  typedef enum logic       {RdIdle, RdSend}          rd_state_e;

  // ---------------------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------------------
  logic                  r_s_ready;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, w_wr_ptr_d;
  logic [ADDR_WIDTH-1:0] r_wr_commit, w_wr_commit_d;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  wr_state_e             r_wr_state, w_wr_state_d;
  logic                  w_s_hs;
  logic [ADDR_WIDTH-1:0] w_free;
  logic                  w_full;
  logic                  w_mem_we;

  logic [EntW-1:0]       r_mem [Depth];

  assign s_axis_tready = r_s_ready;
  assign w_s_hs        = s_axis_tvalid & r_s_ready;
  // Registered rd_ptr makes this conservative by one cycle; one slot always stays empty.
  assign w_free        = MaxFree - (r_wr_ptr - r_rd_ptr);
  assign w_full        = (w_free == '0);

  always_comb begin
    w_wr_state_d  = r_wr_state;
    w_wr_ptr_d    = r_wr_ptr;
    w_wr_commit_d = r_wr_commit;
    w_mem_we      = 1'b0;
    if (w_s_hs) begin
      unique case (r_wr_state)
        WrIdle, WrFrame: begin
          if (w_full) begin
            // Overflow: discard what was written of this frame. A tlast beat ends it here.
            w_wr_ptr_d   = r_wr_commit;
            w_wr_state_d = s_axis_tlast ? WrIdle : WrDrop;
          end else begin
            w_mem_we = 1'b1;
            if (s_axis_tlast) begin
              w_wr_state_d = WrIdle;
              if (s_axis_tuser) begin
                w_wr_ptr_d = r_wr_commit;
              end else begin
                w_wr_ptr_d    = r_wr_ptr + PtrOne;
                w_wr_commit_d = r_wr_ptr + PtrOne;
              end
            end else begin
              w_wr_ptr_d   = r_wr_ptr + PtrOne;
              w_wr_state_d = WrFrame;
            end
          end
        end
        WrDrop: begin
          if (s_axis_tlast) w_wr_state_d = WrIdle;
        end
        default: w_wr_state_d = WrIdle;
      endcase
    end
  end

  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      r_s_ready   <= 1'b0;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_wr_state  <= WrIdle;
    end else begin
      r_s_ready   <= 1'b1;
      r_wr_ptr    <= w_wr_ptr_d;
      r_wr_commit <= w_wr_commit_d;
      r_wr_state  <= w_wr_state_d;
    end
  end

  always_ff @(posedge clk156) begin
    if (w_mem_we) r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // ---------------------------------------------------------------------------------------
  // Read side: RAM (1-cycle latency) feeding a 2-entry output skid buffer
  // ---------------------------------------------------------------------------------------
  logic [EntW-1:0]       r_ram_q;
  logic                  r_ram_vld;
  logic [EntW-1:0]       r_buf0, w_buf0_d;
  logic [EntW-1:0]       r_buf1, w_buf1_d;
  logic [1:0]            r_occ, w_occ_d, w_occ_mid;
  rd_state_e             r_rd_state, w_rd_state_d;
  logic                  w_m_valid;
  logic                  w_pop;
  logic [2:0]            w_fill;
  logic                  w_rd_en;

  assign w_m_valid = (r_rd_state == RdSend) & (r_occ != 2'd0);
  assign w_pop     = w_m_valid & m_axis_tready;
  // Beats held or in flight; a read is issued only if its data will have a skid slot.
  assign w_fill    = {1'b0, r_occ} + {2'b00, r_ram_vld};
  assign w_rd_en   = (r_rd_ptr != r_wr_commit) & ((w_fill - {2'b00, w_pop}) < 3'd2);

  always_ff @(posedge clk156) begin
    if (w_rd_en) r_ram_q <= r_mem[r_rd_ptr];
  end

  always_comb begin
    w_buf0_d  = r_buf0;
    w_buf1_d  = r_buf1;
    w_occ_mid = r_occ;
    if (w_pop) begin
      w_buf0_d  = r_buf1;
      w_occ_mid = r_occ - 2'd1;
    end
    w_occ_d = w_occ_mid;
    if (r_ram_vld) begin
      if (w_occ_mid == 2'd0) w_buf0_d = r_ram_q;
      else                   w_buf1_d = r_ram_q;
      w_occ_d = w_occ_mid + 2'd1;
    end
  end

  always_comb begin
    w_rd_state_d = r_rd_state;
    unique case (r_rd_state)
      RdIdle: if (w_occ_d != 2'd0) w_rd_state_d = RdSend;
      RdSend: begin
        // Stay in RdSend across frames when the next frame is already prefetched.
        if (w_pop && r_buf0[EntW-1] && (w_occ_d == 2'd0)) w_rd_state_d = RdIdle;
      end
      default: w_rd_state_d = RdIdle;
    endcase
  end

  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      r_rd_ptr   <= '0;
      r_ram_vld  <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_occ      <= 2'd0;
      r_rd_state <= RdIdle;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PtrOne;
      r_ram_vld  <= w_rd_en;
      r_buf0     <= w_buf0_d;
      r_buf1     <= w_buf1_d;
      r_occ      <= w_occ_d;
      r_rd_state <= w_rd_state_d;
    end
  end

  assign m_axis_tvalid = w_m_valid;
  assign m_axis_tdata  = r_buf0[DATA_WIDTH-1:0];
  assign m_axis_tkeep  = r_buf0[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tlast  = w_m_valid & r_buf0[EntW-1];
  assign m_axis_tuser  = 1'b0;

  // ---------------------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------------------
`ifdef TX_PKTBUF_STATS_EN
  logic        w_pkt_evt;
  logic        w_drop_evt;
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_drop_cnt;

  assign w_pkt_evt  = w_pop & r_buf0[EntW-1];
  // One drop per frame: bad frame, overflowing tlast beat, or end of an overflowed frame.
  assign w_drop_evt = w_s_hs & s_axis_tlast &
                      ((r_wr_state == WrDrop) | w_full | s_axis_tuser);

  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pkt_evt)  r_pkt_cnt  <= r_pkt_cnt + 32'd1;
      if (w_drop_evt) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;
`else
  assign pkt_cnt  = 32'd0;
  assign drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_eth_tx_pktbuf.sv
// Scoreboard bench for eth_tx_pktbuf: stimulus pushes expected beats of every frame the
// buffer must forward; an independent monitor pops and compares each output handshake.
module tb_eth_tx_pktbuf;

  logic        clk156 = 1'b0;
  logic        eth_rst = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [31:0] pkt_cnt;
  logic [31:0] drop_cnt;

  eth_tx_pktbuf #(
    .DATA_WIDTH(64),
    .KEEP_WIDTH(8),
    .ADDR_WIDTH(9)
  ) dut (
    .clk156       (clk156),
    .eth_rst      (eth_rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk156 = ~clk156;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  localparam int Capacity = 511;

  beat_t sb_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    exp_pkt = 0;
  int    exp_drop = 0;
  int    rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random, 3: never
  int    last_tlast_cyc = 0;

  always @(posedge clk156) cyc <= cyc + 1;

  // Sink ready pattern, changed #1 after each edge.
  initial begin
    forever begin
      @(posedge clk156);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        2:       m_axis_tready = ($urandom_range(0, 3) != 0);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Monitor: evaluates the handshake that the coming rising edge will complete.
  initial begin
    bit    in_frame;
    bit    prev_stall;
    beat_t prev;
    beat_t act;
    beat_t e;
    in_frame   = 0;
    prev_stall = 0;
    prev       = '0;
    forever begin
      @(negedge clk156);
      if (eth_rst) begin
        in_frame   = 0;
        prev_stall = 0;
      end else begin
        act = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (in_frame) begin
          total++;
          if (!m_axis_tvalid) begin
            bad++;
            $display("FAIL gap: tvalid=%0b required=1 at cyc %0d", m_axis_tvalid, cyc);
          end
        end
        if (prev_stall) begin
          total++;
          if (!m_axis_tvalid || act !== prev) begin
            bad++;
            $display("FAIL hold: got v=%0b %h required v=1 %h", m_axis_tvalid, act, prev);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL beat: unexpected output beat %h, none required", act);
          end else begin
            e = sb_q.pop_front();
            if (act !== e || m_axis_tuser !== 1'b0) begin
              bad++;
              $display("FAIL beat: got %h user=%0b required %h user=0", act, m_axis_tuser, e);
            end
            if (e.l) exp_pkt++;
          end
          in_frame = !m_axis_tlast;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev       = act;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Reference model: a frame is forwarded unless flagged bad or longer than the free space,
  // which is the capacity minus the beats still expected at the output.
  task automatic send_frame(input int len, input bit bad_frame, input bit keep0f);
    bit    drop;
    beat_t b;
    drop = bad_frame || (len > Capacity - sb_q.size());
    if (drop) exp_drop++;
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom, $urandom};
      b.k = 8'($urandom);
      b.l = (i == len - 1);
      if (b.l && keep0f) b.k = 8'h0F;
      if (!drop) sb_q.push_back(b);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b.d;
      s_axis_tkeep  = b.k;
      s_axis_tlast  = b.l;
      s_axis_tuser  = b.l ? bad_frame : 1'($urandom);
      if (b.l) last_tlast_cyc = cyc;
      @(posedge clk156);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      @(posedge clk156);
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d beats still pending, required 0", sb_q.size());
    end
    repeat (4) @(posedge clk156);
    #1;
  endtask

  task automatic check_counts(input string name);
`ifdef TX_PKTBUF_STATS_EN
    check({name, "_pkt"}, 64'(pkt_cnt), 64'(exp_pkt));
    check({name, "_drop"}, 64'(drop_cnt), 64'(exp_drop));
`else
    check({name, "_pkt"}, 64'(pkt_cnt), 64'd0);
    check({name, "_drop"}, 64'(drop_cnt), 64'd0);
`endif
  endtask

  initial begin
    int n;
    int len;
    // Reset state
    repeat (3) @(posedge clk156);
    #1;
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_m_tuser", 64'(m_axis_tuser), 64'd0);
    check("rst_m_tdata", m_axis_tdata, 64'd0);
    check("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    check_counts("rst");
    eth_rst = 1'b0;
    @(posedge clk156);
    #1;
    check("rel_s_tready", 64'(s_axis_tready), 64'd1);

    // 8-beat frame, sink always ready; first beat 3 cycles after tlast
    rdy_mode = 0;
    send_frame(8, 0, 1);
    n = 0;
    while (n < 20) begin
      @(negedge clk156);
      if (m_axis_tvalid) break;
      n++;
    end
    check("latency", 64'(cyc - last_tlast_cyc), 64'd3);
    wait_drain(200);
    check_counts("t1");

    // Same frame with ready toggling
    rdy_mode = 1;
    send_frame(8, 0, 1);
    wait_drain(200);
    check_counts("t2");

    // Bad frame then good 4-beat frame
    rdy_mode = 0;
    send_frame(5, 1, 0);
    send_frame(4, 0, 0);
    wait_drain(200);
    check_counts("t3");

    // Overflow: 600-beat frame dropped while sink stalled, 2-beat frame survives
    rdy_mode = 3;
    repeat (2) @(posedge clk156);
    #1;
    send_frame(600, 0, 0);
    send_frame(2, 0, 0);
    repeat (10) @(posedge clk156);
    #1;
    check("stall_valid", 64'(m_axis_tvalid), 64'd1);
    check("stall_pending", 64'(sb_q.size()), 64'd2);
    rdy_mode = 0;
    wait_drain(200);
    check_counts("t4");

    // Capacity boundary: 511 beats fit an empty buffer, 512 do not
    rdy_mode = 3;
    repeat (2) @(posedge clk156);
    #1;
    send_frame(511, 0, 0);
    rdy_mode = 0;
    wait_drain(2000);
    rdy_mode = 3;
    repeat (2) @(posedge clk156);
    #1;
    send_frame(512, 0, 0);
    rdy_mode = 0;
    wait_drain(200);
    check_counts("t5");

    // 60 back-to-back 8-beat frames while draining with random ready
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) send_frame(8, 0, 0);
    wait_drain(5000);
    check_counts("t6");

    // Random frames, lengths, bad flags, gaps and sink patterns
    for (int i = 0; i < 40; i++) begin
      len      = $urandom_range(1, 24);
      rdy_mode = $urandom_range(0, 2);
      n = 0;
      while (sb_q.size() + len > 400 && n < 2000) begin
        @(posedge clk156);
        n++;
      end
      #1;
      send_frame(len, ($urandom_range(0, 4) == 0), 0);
      repeat ($urandom_range(0, 2)) @(posedge clk156);
      #1;
    end
    rdy_mode = 0;
    wait_drain(5000);
    check_counts("t7");

    // Reset in the middle of a 16-beat frame
    send_frame(16, 0, 0);
    n = 0;
    while (!m_axis_tvalid && n < 20) begin
      @(posedge clk156);
      #1;
      n++;
    end
    repeat (5) @(posedge clk156);
    #1;
    eth_rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    sb_q.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    repeat (3) @(posedge clk156);
    #1;
    eth_rst = 1'b0;
    repeat (30) @(posedge clk156);
    #1;
    check("post_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("post_rst_s_tready", 64'(s_axis_tready), 64'd1);
    check_counts("t8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
